pwm_counter: RTL and testbench
==============================

# pwm_counter

Timebase counter for the PWM peripheral: produces the running `count_val` consumed by the PWM generator stage. It combines an 8-bit prescaler, an up/down 16-bit counter that wraps at a programmable period, and shadow registers so that register writes take effect only at period boundaries. It sits between the register file (period, prescale, direction, enable, reset strobe) and the PWM output logic.

## Interface
- `WIDTH`, 16: counter and period width.
- `PSC_W`, 8: prescaler field width.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  counter enable, from the register file.
- `count_reset`  in  1  single-cycle synchronous clear strobe, from the register file.
- `period`  in  WIDTH  wrap value N; the count range is 0..N inclusive.
- `prescale`  in  PSC_W  divide value P; the counter advances once every P+1 clk cycles.
- `upnotdown`  in  1  1 = count up, 0 = count down.
- `count_val`  out  WIDTH  current registered count, to the PWM generator.
- `period_done`  out  1  single-cycle pulse, asserted in the cycle `count_val` shows the wrap value.

## Operation
- Internal state:
  - prescaler counter `pcnt` (PSC_W bits).
  - shadows `period_sh`, `psc_sh`, `dir_sh`.
  - `count` drives `count_val`.
- Shadow load:
  - Shadows copy `period`/`prescale`/`upnotdown` every cycle while `en`=0.
  - They also copy on `count_reset`.
  - They also copy on every wrap event.
  - Otherwise they hold, so mid-period writes apply from the next period.
- Tick: `tick` = `en` && (`pcnt` == `psc_sh`).
  - On tick, `pcnt` <= 0; otherwise, while `en`=1, `pcnt` <= `pcnt`+1.
  - `psc_sh`=0 gives a tick every cycle.
- Up mode (`dir_sh`=1), on tick:
  - If `count` >= `period_sh`: wrap event, `count` <= 0.
  - Else `count` <= `count`+1.
- Down mode (`dir_sh`=0), on tick:
  - If `count`=0 or `count` > `period_sh`: wrap event, `count` <= `period_sh`.
  - Else `count` <= `count`−1.
- Wrap value comes from the shadow before reload. The new shadow applies to the following period.
- `period_done` <= 1 on a wrap event, 0 otherwise.
- `period_sh`=0: `count` stays 0 and `period_done` pulses on every tick.
- `en`=0:
  - `count` holds.
  - `pcnt` <= 0.
  - `period_done` <= 0.
  - No wrap events occur.
- `count_reset`=1 takes priority over tick and `en`:
  - `pcnt` <= 0.
  - `count` <= 0 if `upnotdown`=1, else `count` <= `period` (uses the input values, not the shadows).
  - `period_done` <= 0.
- Arithmetic is unsigned WIDTH-bit. No intermediate overflow is possible, because `count` never increments past `period_sh`.
- Direction changes while running take effect at the next wrap only.

## Timing
- Reset (async assert, sync release): `count_val`=0, `period_done`=0, `pcnt`=0, `period_sh`=0, `psc_sh`=0, `dir_sh`=1.
- After `en` rises with P=`psc_sh`, the first `count_val` change is visible P+1 clk edges later. Each step after that takes P+1 cycles.
- `count_val` and `period_done` are both registered and update on the same edge. There is no combinational path from inputs to outputs.
- `count_reset` is visible on `count_val` one edge after the strobe.
- Full period in up or down mode = (N+1)·(P+1) clk cycles. `period_done` pulses once per period and is 1 cycle wide, regardless of P.
- Reset mid-operation: all state returns to reset values immediately. Counting resumes only with `en`=1 after `rst_n` deasserts.

## Test plan
1. Up count, N=4, P=0, en=1:
   - `count_val` sequence 0,1,2,3,4,0,1…
   - `period_done` high exactly in the cycles showing 0 after 4, i.e. period 5 cycles.
2. Down count, N=3, P=2:
   - Each value held 3 cycles, sequence 3,2,1,0,3…
   - `period_done` one cycle wide at each reload to 3, every 12 cycles.
3. Shadowing, up, N=10:
   - Write N=5 while `count_val`=3: counting continues to 10, wraps to 0, then wraps after 5.
   - Same for a direction flip, which applies only after the wrap.
4. Enable/disable:
   - Drop `en` at `count_val`=7: value holds 7 for 20 cycles, no `period_done`.
   - Raise `en` with P=1: next value 8 appears 2 edges later.
   - Disable with N lowered to 4 while count=7, then re-enable: next tick wraps to 0 with `period_done` pulse.
5. `count_reset`:
   - Mid-count in up mode: next `count_val`=0, prescaler restarted.
   - Down mode with `period`=9: next `count_val`=9.
   - Strobe coincident with a tick: reset wins, no `period_done`.
6. Edge cases:
   - N=0: `count_val` constant 0, `period_done` every tick.
   - P=255: exactly 256 cycles per step.
   - Assert `rst_n`=0 asynchronously mid-period: outputs 0 with no clk edge.

Source files
------------

// File: rtl/pwm_counter_if.sv
// Register-file side bundle for the PWM timebase counter.
// The master is the register file and PWM generator. The slave is the counter.
interface pwm_counter_if #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
);
  logic             en;
  logic             count_reset;
  logic [WIDTH-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic             upnotdown;
  logic [WIDTH-1:0] count_val;
  logic             period_done;

  modport master (
    output en,
    output count_reset,
    output period,
    output prescale,
    output upnotdown,
    input  count_val,
    input  period_done
  );

  modport slave (
    input  en,
    input  count_reset,
    input  period,
    input  prescale,
    input  upnotdown,
    output count_val,
    output period_done
  );
endinterface

// File: rtl/pwm_counter.sv
// PWM timebase: the prescaler feeds an up/down counter that wraps at a shadowed period.
// Period, prescale and direction are shadowed so that writes land only at period boundaries.
module pwm_counter #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ZERO = {PSC_W{1'b0}};
  localparam logic [PSC_W-1:0] PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;
  logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
  logic             dir_sh_q, dir_sh_d;
  logic             period_done_q, period_done_d;

  logic             tick_s;
  logic             wrap_s;
  logic             load_sh_s;

  // Tick and wrap detection. The wrap decision uses the shadows from before the reload.
  always_comb begin
    tick_s = bus.en && (pcnt_q == psc_sh_q);
    wrap_s = 1'b0;
    if (tick_s) begin
      if (dir_sh_q) begin
        wrap_s = (count_q >= period_sh_q);
      end else begin
        wrap_s = (count_q == CNT_ZERO) || (count_q > period_sh_q);
      end
    end else begin
      wrap_s = 1'b0;
    end
    load_sh_s = bus.count_reset || !bus.en || wrap_s;
  end

  // Shadow reload: the shadows follow the inputs while idle, on a clear strobe, or at a wrap.
  always_comb begin
    period_sh_d = period_sh_q;
    psc_sh_d    = psc_sh_q;
    dir_sh_d    = dir_sh_q;
    if (load_sh_s) begin
      period_sh_d = bus.period;
      psc_sh_d    = bus.prescale;
      dir_sh_d    = bus.upnotdown;
    end else begin
      period_sh_d = period_sh_q;
      psc_sh_d    = psc_sh_q;
      dir_sh_d    = dir_sh_q;
    end
  end

  // Prescaler and counter next state. A clear strobe overrides both enable and tick.
  always_comb begin
    pcnt_d        = pcnt_q;
    count_d       = count_q;
    period_done_d = 1'b0;
    if (bus.count_reset) begin
      pcnt_d        = PSC_ZERO;
      count_d       = bus.upnotdown ? CNT_ZERO : bus.period;
      period_done_d = 1'b0;
    end else if (!bus.en) begin
      pcnt_d        = PSC_ZERO;
      count_d       = count_q;
      period_done_d = 1'b0;
    end else if (tick_s) begin
      pcnt_d = PSC_ZERO;
      if (wrap_s) begin
        count_d       = dir_sh_q ? CNT_ZERO : period_sh_q;
        period_done_d = 1'b1;
      end else if (dir_sh_q) begin
        count_d       = count_q + CNT_ONE;
        period_done_d = 1'b0;
      end else begin
        count_d       = count_q - CNT_ONE;
        period_done_d = 1'b0;
      end
    end else begin
      pcnt_d        = pcnt_q + PSC_ONE;
      count_d       = count_q;
      period_done_d = 1'b0;
    end
  end

  // State registers. dir_sh resets to count-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= CNT_ZERO;
      pcnt_q        <= PSC_ZERO;
      period_sh_q   <= CNT_ZERO;
      psc_sh_q      <= PSC_ZERO;
      dir_sh_q      <= 1'b1;
      period_done_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      pcnt_q        <= pcnt_d;
      period_sh_q   <= period_sh_d;
      psc_sh_q      <= psc_sh_d;
      dir_sh_q      <= dir_sh_d;
      period_done_q <= period_done_d;
    end
  end

  assign bus.count_val   = count_q;
  assign bus.period_done = period_done_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter. Inputs are driven and outputs are sampled on the falling clock edge.
module tb_pwm_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pwm_counter_if #(.WIDTH(16), .PSC_W(8)) bus ();

  pwm_counter #(.WIDTH(16), .PSC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clear strobe with the given settings. The counter is left disabled.
  task automatic restart(input logic [15:0] n, input logic [7:0] p, input logic up);
    bus.en          = 1'b0;
    bus.period      = n;
    bus.prescale    = p;
    bus.upnotdown   = up;
    bus.count_reset = 1'b1;
    step(1);
    bus.count_reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.count_reset = 1'b0; bus.period = 16'd0;
    bus.prescale = 8'd0; bus.upnotdown = 1'b1;
    rst_n = 1'b0;
    step(3);
    checks++;
    if (bus.count_val !== 16'd0 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d done=%b, want 0/0", bus.count_val, bus.period_done);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_up_count();
    logic [15:0] exp_c;
    logic        exp_d;
    bus.period = 16'd4; bus.prescale = 8'd0; bus.upnotdown = 1'b1;
    step(1);
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      exp_c = 16'(i % 5);
      exp_d = (i % 5 == 0);
      checks++;
      if (bus.count_val !== exp_c || bus.period_done !== exp_d) begin
        errors++;
        $display("FAIL up_count[%0d]: count=%0d done=%b, want %0d/%b", i, bus.count_val, bus.period_done, exp_c, exp_d);
      end
    end
  endtask

  task automatic test_down_count();
    logic [15:0] exp_c;
    logic        exp_d;
    restart(16'd3, 8'd2, 1'b0);
    checks++;
    if (bus.count_val !== 16'd3 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL down_load: count=%0d done=%b, want 3/0", bus.count_val, bus.period_done);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step(1);
      exp_c = 16'(3 - ((i / 3) % 4));
      exp_d = (i % 12 == 0);
      checks++;
      if (bus.count_val !== exp_c || bus.period_done !== exp_d) begin
        errors++;
        $display("FAIL down_count[%0d]: count=%0d done=%b, want %0d/%b", i, bus.count_val, bus.period_done, exp_c, exp_d);
      end
    end
  endtask

  task automatic test_shadow();
    logic [15:0] exp_c;
    logic        exp_d;
    restart(16'd10, 8'd0, 1'b1);
    bus.en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      if (i <= 10)      begin exp_c = 16'(i);      exp_d = 1'b0; end
      else if (i == 11) begin exp_c = 16'd0;       exp_d = 1'b1; end
      else if (i <= 16) begin exp_c = 16'(i - 11); exp_d = 1'b0; end
      else              begin exp_c = 16'd0;       exp_d = 1'b1; end
      checks++;
      if (bus.count_val !== exp_c || bus.period_done !== exp_d) begin
        errors++;
        $display("FAIL shadow_period[%0d]: count=%0d done=%b, want %0d/%b", i, bus.count_val, bus.period_done, exp_c, exp_d);
      end
      if (i == 3) bus.period = 16'd5;
    end
    // The direction flip lands at the wrap to 0. Down mode then reloads at once from 0.
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (k <= 5)      begin exp_c = 16'(k);      exp_d = 1'b0; end
      else if (k == 6) begin exp_c = 16'd0;       exp_d = 1'b1; end
      else if (k == 7) begin exp_c = 16'd5;       exp_d = 1'b1; end
      else             begin exp_c = 16'(12 - k); exp_d = 1'b0; end
      checks++;
      if (bus.count_val !== exp_c || bus.period_done !== exp_d) begin
        errors++;
        $display("FAIL shadow_dir[%0d]: count=%0d done=%b, want %0d/%b", k, bus.count_val, bus.period_done, exp_c, exp_d);
      end
      if (k == 2) bus.upnotdown = 1'b0;
    end
  endtask

  task automatic test_enable();
    restart(16'd10, 8'd0, 1'b1);
    bus.en = 1'b1;
    step(7);
    bus.en = 1'b0;
    bus.prescale = 8'd1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      checks++;
      if (bus.count_val !== 16'd7 || bus.period_done !== 1'b0) begin
        errors++;
        $display("FAIL en_hold[%0d]: count=%0d done=%b, want 7/0", i, bus.count_val, bus.period_done);
      end
    end
    bus.en = 1'b1;
    step(1);
    checks++;
    if (bus.count_val !== 16'd7) begin
      errors++;
      $display("FAIL en_resume_early: count=%0d, want 7", bus.count_val);
    end
    step(1);
    checks++;
    if (bus.count_val !== 16'd8) begin
      errors++;
      $display("FAIL en_resume: count=%0d, want 8", bus.count_val);
    end
    restart(16'd10, 8'd0, 1'b1);
    bus.en = 1'b1;
    step(7);
    bus.en = 1'b0;
    bus.period = 16'd4;
    step(3);
    checks++;
    if (bus.count_val !== 16'd7) begin
      errors++;
      $display("FAIL en_lower_hold: count=%0d, want 7", bus.count_val);
    end
    bus.en = 1'b1;
    step(1);
    checks++;
    if (bus.count_val !== 16'd0 || bus.period_done !== 1'b1) begin
      errors++;
      $display("FAIL en_lower_wrap: count=%0d done=%b, want 0/1", bus.count_val, bus.period_done);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_count_reset();
    restart(16'd10, 8'd2, 1'b1);
    bus.en = 1'b1;
    step(7);
    checks++;
    if (bus.count_val !== 16'd2) begin
      errors++;
      $display("FAIL crst_pre: count=%0d, want 2", bus.count_val);
    end
    bus.count_reset = 1'b1;
    step(1);
    bus.count_reset = 1'b0;
    checks++;
    if (bus.count_val !== 16'd0 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL crst_up: count=%0d done=%b, want 0/0", bus.count_val, bus.period_done);
    end
    step(2);
    checks++;
    if (bus.count_val !== 16'd0) begin
      errors++;
      $display("FAIL crst_psc_restart: count=%0d, want 0", bus.count_val);
    end
    step(1);
    checks++;
    if (bus.count_val !== 16'd1) begin
      errors++;
      $display("FAIL crst_first_step: count=%0d, want 1", bus.count_val);
    end
    bus.upnotdown = 1'b0; bus.period = 16'd9; bus.count_reset = 1'b1;
    step(1);
    bus.count_reset = 1'b0;
    checks++;
    if (bus.count_val !== 16'd9 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL crst_down: count=%0d done=%b, want 9/0", bus.count_val, bus.period_done);
    end
    // With N=0 and P=0, every edge is a wrapping tick, so the strobe collides with one.
    restart(16'd0, 8'd0, 1'b1);
    bus.en = 1'b1;
    step(1);
    checks++;
    if (bus.period_done !== 1'b1) begin
      errors++;
      $display("FAIL crst_tick_setup: done=%b, want 1", bus.period_done);
    end
    bus.upnotdown = 1'b0; bus.period = 16'd6; bus.count_reset = 1'b1;
    step(1);
    bus.count_reset = 1'b0;
    checks++;
    if (bus.count_val !== 16'd6 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL crst_vs_tick: count=%0d done=%b, want 6/0", bus.count_val, bus.period_done);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_edges();
    logic exp_d;
    restart(16'd0, 8'd1, 1'b1);
    bus.en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      exp_d = (i % 2 == 0);
      checks++;
      if (bus.count_val !== 16'd0 || bus.period_done !== exp_d) begin
        errors++;
        $display("FAIL n0[%0d]: count=%0d done=%b, want 0/%b", i, bus.count_val, bus.period_done, exp_d);
      end
    end
    restart(16'd10, 8'd255, 1'b1);
    bus.en = 1'b1;
    step(255);
    checks++;
    if (bus.count_val !== 16'd0) begin
      errors++;
      $display("FAIL p255_a: count=%0d, want 0", bus.count_val);
    end
    step(1);
    checks++;
    if (bus.count_val !== 16'd1) begin
      errors++;
      $display("FAIL p255_b: count=%0d, want 1", bus.count_val);
    end
    step(255);
    checks++;
    if (bus.count_val !== 16'd1) begin
      errors++;
      $display("FAIL p255_c: count=%0d, want 1", bus.count_val);
    end
    step(1);
    checks++;
    if (bus.count_val !== 16'd2) begin
      errors++;
      $display("FAIL p255_d: count=%0d, want 2", bus.count_val);
    end
    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count_val !== 16'd0 || bus.period_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d done=%b, want 0/0", bus.count_val, bus.period_done);
    end
    step(1);
    rst_n = 1'b1;
    // After reset the shadows hold N=0, P=0 and up, so with en still high the first tick wraps.
    step(1);
    checks++;
    if (bus.count_val !== 16'd0 || bus.period_done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_shadow: count=%0d done=%b, want 0/1", bus.count_val, bus.period_done);
    end
    bus.en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_up_count();
    test_down_count();
    test_shadow();
    test_enable();
    test_count_reset();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
